// File: rtl/dlx_rf_pkg.sv
// Shared definitions for the SIMD DLX register-file write path.
package dlx_rf_pkg;

  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned REG_ZERO = 0;

  // A single requester still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first eligible index at or above rr_ptr, wrapping.
module rr_picker
  import dlx_rf_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  int unsigned w_idx;

  // Walk offsets from highest to lowest so the closest eligible index is assigned last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = 0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      w_idx = int'(rr_ptr) + unsigned'(i);
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (eligible[IW'(w_idx)]) begin
        winner = IW'(w_idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N_REQ write-back sources.
module rf_wr_arbiter
  import dlx_rf_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] wr_addr,
  input  logic [N_REQ*DW-1:0] wr_data,
  input  logic                rf_stall,
  output logic [N_REQ-1:0]    ack,
  output logic                rf_we,
  output logic [AW-1:0]       rf_addr,
  output logic [DW-1:0]       rf_data,
  output logic                r0_drop
);

  localparam int unsigned IW = idx_width(N_REQ);

  logic [N_REQ-1:0] r_ack;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_data;
  logic             r_drop;
  logic [IW-1:0]    r_rr_ptr;

  logic [N_REQ-1:0] w_eligible;
  logic [IW-1:0]    w_winner;
  logic             w_valid;
  logic             w_grant;
  logic [N_REQ-1:0] w_onehot;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_data;
  logic [IW-1:0]    w_ptr_nxt;
  logic             w_is_r0;

  // The requester being acked still shows its old request, so mask it out.
  assign w_eligible = req & ~r_ack;
  assign w_grant    = w_valid & ~rf_stall;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .eligible (w_eligible),
    .rr_ptr   (r_rr_ptr),
    .winner   (w_winner),
    .valid    (w_valid)
  );

  always_comb begin
    w_onehot   = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_winner == IW'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_addr  = wr_addr[i*AW +: AW];
        w_sel_data  = wr_data[i*DW +: DW];
      end
    end
  end

  assign w_ptr_nxt = (w_winner == IW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_is_r0   = (w_sel_addr == AW'(REG_ZERO));

  // Handshake and write-enable strobes: clear whenever nothing is granted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ack  <= '0;
      r_we   <= 1'b0;
      r_drop <= 1'b0;
    end else if (w_grant) begin
      r_ack  <= w_onehot;
      r_we   <= ~w_is_r0;
      r_drop <= w_is_r0;
    end else begin
      r_ack  <= '0;
      r_we   <= 1'b0;
      r_drop <= 1'b0;
    end
  end

  // Address, data and pointer hold their value when nothing is granted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_addr   <= w_sel_addr;
      r_data   <= w_sel_data;
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign ack     = r_ack;
  assign rf_we   = r_we;
  assign rf_addr = r_addr;
  assign rf_data = r_data;
  assign r0_drop = r_drop;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter with hand-computed expectations.
module tb_rf_wr_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic                CLK;
  logic                RESET;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] wr_addr;
  logic [N_REQ*DW-1:0] wr_data;
  logic                rf_stall;
  logic [N_REQ-1:0]    ack;
  logic                rf_we;
  logic [AW-1:0]       rf_addr;
  logic [DW-1:0]       rf_data;
  logic                r0_drop;

  int n_vec;
  int n_err;

  rf_wr_arbiter #(
    .N_REQ (N_REQ),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rf_stall (rf_stall),
    .ack      (ack),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .r0_drop  (r0_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_ack, input logic e_we,
                           input logic [4:0] e_addr, input logic [31:0] e_data,
                           input logic e_drop);
    check({tag, ".ack"}, 64'(ack), 64'(e_ack));
    check({tag, ".we"}, 64'(rf_we), 64'(e_we));
    check({tag, ".addr"}, 64'(rf_addr), 64'(e_addr));
    check({tag, ".data"}, 64'(rf_data), 64'(e_data));
    check({tag, ".drop"}, 64'(r0_drop), 64'(e_drop));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    RESET    = 1'b1;
    req      = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rf_stall = 1'b0;
    #1;
    check_out("reset_t0", 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    tick();
    RESET = 1'b0;
    check_out("reset", 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0);

    // Single requester 2, held: acks every second cycle. Pointer ends at 3.
    wr_addr[2*AW +: AW] = 5'd7;
    wr_data[2*DW +: DW] = 32'hDEADBEEF;
    req = 4'b0100;
    tick();
    check_out("single_1", 4'b0100, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    tick();
    check_out("single_gap", 4'b0000, 1'b0, 5'd7, 32'hDEADBEEF, 1'b0);
    tick();
    check_out("single_2", 4'b0100, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    req = 4'b0000;
    tick();
    check_out("single_idle", 4'b0000, 1'b0, 5'd7, 32'hDEADBEEF, 1'b0);

    // R0 write from requester 1: acked but dropped. Pointer ends at 2.
    wr_addr[1*AW +: AW] = 5'd0;
    wr_data[1*DW +: DW] = 32'h11111111;
    req = 4'b0010;
    tick();
    check_out("r0_write", 4'b0010, 1'b0, 5'd0, 32'h11111111, 1'b1);
    req = 4'b0000;
    tick();
    check_out("r0_after", 4'b0000, 1'b0, 5'd0, 32'h11111111, 1'b0);

    // Wrap: grant to 2 moves pointer to 3; then 3 wins over 0, then 0.
    wr_addr[2*AW +: AW] = 5'd9;
    wr_data[2*DW +: DW] = 32'h00000022;
    req = 4'b0100;
    tick();
    check_out("wrap_g2", 4'b0100, 1'b1, 5'd9, 32'h00000022, 1'b0);
    wr_addr[0*AW +: AW] = 5'd1;
    wr_data[0*DW +: DW] = 32'h000000A0;
    wr_addr[3*AW +: AW] = 5'd3;
    wr_data[3*DW +: DW] = 32'h000000A3;
    req = 4'b1001;
    tick();
    check_out("wrap_g3", 4'b1000, 1'b1, 5'd3, 32'h000000A3, 1'b0);
    req = 4'b0001;
    tick();
    check_out("wrap_g0", 4'b0001, 1'b1, 5'd1, 32'h000000A0, 1'b0);
    req = 4'b0000;
    tick();
    check_out("wrap_idle", 4'b0000, 1'b0, 5'd1, 32'h000000A0, 1'b0);

    // Stall for 3 cycles with pointer at 1; pointer must not move.
    wr_addr[1*AW +: AW] = 5'd2;
    wr_data[1*DW +: DW] = 32'h000000B1;
    rf_stall = 1'b1;
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 4'b0000, 1'b0, 5'd1, 32'h000000A0, 1'b0);
    end
    rf_stall = 1'b0;
    tick();
    check_out("stall_rel_g1", 4'b0010, 1'b1, 5'd2, 32'h000000B1, 1'b0);
    tick();
    check_out("stall_rel_g0", 4'b0001, 1'b1, 5'd1, 32'h000000A0, 1'b0);
    // Stall while ack is high: visible write stands, next grant waits.
    rf_stall = 1'b1;
    tick();
    check_out("stall_inflight", 4'b0000, 1'b0, 5'd1, 32'h000000A0, 1'b0);
    rf_stall = 1'b0;
    tick();
    check_out("stall_resume", 4'b0010, 1'b1, 5'd2, 32'h000000B1, 1'b0);
    req = 4'b0000;
    tick();

    // Full contention from pointer 2, then a mid-cycle reset.
    for (int i = 0; i < 4; i++) begin
      wr_addr[i*AW +: AW] = 5'(i + 4);
      wr_data[i*DW +: DW] = 32'hC0000000 + 32'(i);
    end
    req = 4'b1111;
    tick();
    check_out("pre_reset", 4'b0100, 1'b1, 5'd6, 32'hC0000002, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    check_out("reset_async", 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    RESET = 1'b0;
    tick();
    check_out("rr_0", 4'b0001, 1'b1, 5'd4, 32'hC0000000, 1'b0);
    tick();
    check_out("rr_1", 4'b0010, 1'b1, 5'd5, 32'hC0000001, 1'b0);
    tick();
    check_out("rr_2", 4'b0100, 1'b1, 5'd6, 32'hC0000002, 1'b0);
    tick();
    check_out("rr_3", 4'b1000, 1'b1, 5'd7, 32'hC0000003, 1'b0);
    tick();
    check_out("rr_4", 4'b0001, 1'b1, 5'd4, 32'hC0000000, 1'b0);
    req = 4'b0000;
    tick();
    check_out("end_idle", 4'b0000, 1'b0, 5'd4, 32'hC0000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port of the SIMD DLX datapath between N_REQ write-back requesters, for example the SIMD lanes and the load unit.
- Uses round-robin arbitration with a registered grant and a one-cycle acknowledge handshake.
- Drives the register bank's write-enable, address and data, and suppresses writes to R0.
- Sits between the write-back stage sources and the register-file flop array.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width

Ports:
- CLK  input  1  system clock, all state updates on its rising edge
- RESET  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester write request; level-sensitive, held until acked
- wr_addr  input  N_REQ*AW  packed per-requester destination register; requester i uses bits [i*AW +: AW]
- wr_data  input  N_REQ*DW  packed per-requester write data; requester i uses bits [i*DW +: DW]
- rf_stall  input  1  datapath freeze; no new grant is issued while it is high
- ack  output  N_REQ  one-hot, one-cycle pulse; request accepted
- rf_we  output  1  register-file write enable
- rf_addr  output  AW  register-file write address
- rf_data  output  DW  register-file write data
- r0_drop  output  1  pulses when a granted write targeted R0 and was discarded

Behaviour:
- Interface: one clock CLK; RESET is asynchronous and active-high.
- Reset values: ack=0, rf_we=0, rf_addr=0, rf_data=0, r0_drop=0, rr_ptr=0. All are cleared immediately on RESET assertion, independent of CLK.
- Eligible set in cycle t: eligible = req & ~ack. The requester being acknowledged this cycle is excluded, because it still shows its old request.
- Arbitration: when rf_stall=0 and eligible≠0, the winner is the first eligible index searching from rr_ptr upward, wrapping modulo N_REQ.
- Registered outputs at the edge ending cycle t:
  - ack[winner]=1
  - rf_addr = wr_addr[winner]
  - rf_data = wr_data[winner]
  - rf_we = (wr_addr[winner] != 0)
  - r0_drop = (wr_addr[winner] == 0)
  - rr_ptr = (winner+1) mod N_REQ
- Latency: one cycle from sampled req to ack, rf_we and data. The register file commits on the following edge.
- No winner (eligible=0 or rf_stall=1): ack=0, rf_we=0, r0_drop=0. rf_addr and rf_data hold their previous values. rr_ptr holds.
- Requester contract:
  - keep req, wr_addr and wr_data stable until ack is seen;
  - in the cycle ack is high, it may drop req or present a new request;
  - a new request is eligible from the next cycle, so one requester gets at most one grant every 2 cycles.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,… and every requester waits at most N_REQ cycles.
- rf_stall asserted while ack is high: the in-flight write completes, because it was already registered. Grants resume in the cycle after rf_stall falls.
- Wrap-around: rr_ptr wraps from N_REQ-1 to 0. The search is modular.
- Reset mid-operation: an in-flight ack or write is cancelled. Requesters keep req asserted and are re-arbitrated from rr_ptr=0 once RESET falls.
- Width rules: the winner index is $clog2(N_REQ) bits wide. The packed-slice selection uses the winner index only; no arithmetic is done on data.

Decomposition:
- Shared package dlx_rf_pkg holds:
  - the AW and DW defaults;
  - the R0 address constant (REG_ZERO = 0);
  - a function that computes winner-index width from N_REQ.
- Sub-module rr_picker is purely combinational. Inputs: eligible and rr_ptr. Outputs: winner index and valid.
- The parent holds:
  - the rr_ptr register;
  - the output registers, each an asynchronous-reset flop bank.

Test Plan:
- Reset check: assert RESET mid-cycle with req=4'b1111 → all outputs are 0 immediately, with no CLK edge. After release, the first ack is 4'b0001.
- Single requester: req=4'b0100, wr_addr[2]=7, wr_data[2]=0xDEADBEEF → the next cycle shows ack=4'b0100, rf_we=1, rf_addr=7, rf_data=0xDEADBEEF. If req is held continuously, acks arrive every 2nd cycle.
- Full contention: req=4'b1111 held, each requester gives new data per ack → the ack sequence is 0001, 0010, 0100, 1000, 0001 and there is never a repeat back-to-back.
- R0 write: req=4'b0010, wr_addr[1]=0 → ack=4'b0010, rf_we=0, r0_drop=1 for one cycle.
- Stall: req=4'b0011 with rf_stall=1 for 3 cycles → ack=0 and rf_we=0 throughout. When rf_stall falls, ack=4'b0001 one cycle later and rr_ptr is unchanged.
- Wrap: rr_ptr=3 after a grant to 2, with req=4'b1001 → the grant goes to 3, then to 0.
